smbus_mailbox_mp_reg_file: RTL and testbench

Multi-host successor to the SMBus mailbox register file. It holds the byte-wide mailbox register space and the shared provisioning FIFO. NUM_HOSTS SMBus-to-AVMM host channels (PCH, BMC and further hosts) reach it through one arbitrated RAM port, and the Nios reaches it through a dedicated port. New relative to the two-host version: round-robin host arbitration, m0/host collision stalls, FIFO full/empty protection with sticky error flags, and per-host doorbell interrupts to the Nios.

---
 rtl/platform_defs_pkg.sv | 20 ++
 rtl/mailbox_rr_arbiter.sv | 43 ++++
 rtl/smbus_mailbox_mp_reg_file.sv | 182 ++++++++++++++++++
 tb/tb_smbus_mailbox_mp_reg_file.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_defs_pkg.sv
// Platform-wide mailbox constants and host write-permission map.
// Each SMBus host owns a 16-byte region at 0x80 + 16*host, plus the shared FIFO and trigger registers.
package platform_defs_pkg;

  localparam logic [7:0] WRITE_FIFO_ADDR      = 8'h0B;
  localparam logic [7:0] READ_FIFO_ADDR       = 8'h0C;
  localparam logic [7:0] COMMAND_TRIGGER_ADDR = 8'h0D;

  localparam int SMBUS_MAILBOX_FIFO_DEPTH = 8;

  // Host 0 (PCH) -> 0x80..0x8F, host 1 (BMC) -> 0x90..0x9F, and so on up to host 7.
  function automatic logic host_mailbox_writable_address(input int unsigned host,
                                                         input logic [7:0] addr);
    logic [3:0] region;
    region = 4'h8 + {1'b0, host[2:0]};
    return (addr == WRITE_FIFO_ADDR) || (addr == COMMAND_TRIGGER_ADDR) ||
           (addr[7:4] == region);
  endfunction

endpackage

// File: rtl/mailbox_rr_arbiter.sv
// Round-robin grant among mailbox host channels; the pointer only advances on a completed grant.
module mailbox_rr_arbiter #(
  parameter int NUM_HOSTS = 2,
  localparam int IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_HOSTS-1:0] req_i,
  input  logic                 stall_i,
  output logic [NUM_HOSTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_o      = '0;
    grant_idx_o  = last_grant_q;
    found        = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 1; k <= NUM_HOSTS; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_HOSTS;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
    last_grant_d = last_grant_q;
    if (found && !stall_i) last_grant_d = grant_idx_o;
  end

  always_ff @(posedge clk) begin
    if (!resetn) last_grant_q <= IDX_W'(NUM_HOSTS - 1);
    else         last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/smbus_mailbox_mp_reg_file.sv
// Byte-wide mailbox register file shared by the Nios (m0) and NUM_HOSTS arbitrated SMBus hosts,
// with the provisioning FIFO, sticky FIFO error flags and per-host doorbells.
module smbus_mailbox_mp_reg_file
  import platform_defs_pkg::*;
#(
  parameter int NUM_HOSTS  = 2,
  parameter int FIFO_DEPTH = SMBUS_MAILBOX_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          m0_read,
  input  logic                          m0_write,
  input  logic [7:0]                    m0_address,
  input  logic [7:0]                    m0_writedata,
  output logic [31:0]                   m0_readdata,
  output logic                          m0_readdatavalid,
  input  logic [NUM_HOSTS-1:0]          h_read,
  input  logic [NUM_HOSTS-1:0]          h_write,
  input  logic [8*NUM_HOSTS-1:0]        h_address,
  input  logic [8*NUM_HOSTS-1:0]        h_writedata,
  output logic [32*NUM_HOSTS-1:0]       h_readdata,
  output logic [NUM_HOSTS-1:0]          h_readdatavalid,
  output logic [NUM_HOSTS-1:0]          h_waitrequest,
  output logic [NUM_HOSTS-1:0]          h_invalid_cmd,
  output logic [NUM_HOSTS-1:0]          doorbell_irq,
  input  logic [NUM_HOSTS-1:0]          doorbell_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);

  localparam int IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]           mem_q [256];
  logic [7:0]           fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, unf_q;
  logic [NUM_HOSTS-1:0] irq_q;
  logic                 m0_rvalid_q;
  logic [7:0]           m0_rdata_q;
  logic [NUM_HOSTS-1:0] h_rvalid_q;
  logic [7:0]           h_rdata_q;

  logic [NUM_HOSTS-1:0] h_req, grant, db_set;
  logic [IDX_W-1:0]     g_idx;
  logic [7:0]           g_addr, g_wdata, head, m0_rval, h_rval, push_data;
  logic                 g_req, g_rd, g_wr, stall, g_acc, g_writable, g_wr_ok;
  logic                 m0_push, h_push, m0_pop_req, h_pop_req, push, pop, clear;
  logic                 ovf_evt, unf_evt, h_ovf;

  assign h_req = h_read | h_write;

  mailbox_rr_arbiter #(.NUM_HOSTS(NUM_HOSTS)) u_arb (
    .clk         (clk),
    .resetn      (resetn),
    .req_i       (h_req),
    .stall_i     (stall),
    .grant_o     (grant),
    .grant_idx_o (g_idx)
  );

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_rd    = 1'b0;
    g_wr    = 1'b0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      if (grant[i]) begin
        g_addr  = h_address[i*8 +: 8];
        g_wdata = h_writedata[i*8 +: 8];
        g_rd    = h_read[i];
        g_wr    = h_write[i];
      end
    end
  end

  assign g_req = |grant;
  // m0 is never stalled, so every conflict with it is resolved by holding the host off.
  assign stall = g_req &&
                 ((m0_write && (m0_address == g_addr)) ||
                  ((m0_read || m0_write) &&
                   ((m0_address == WRITE_FIFO_ADDR) || (m0_address == READ_FIFO_ADDR)) &&
                   ((g_addr == WRITE_FIFO_ADDR) || (g_addr == READ_FIFO_ADDR))) ||
                  (m0_write && (m0_address == COMMAND_TRIGGER_ADDR)));
  assign g_acc      = g_req && !stall;
  assign g_writable = host_mailbox_writable_address(32'(g_idx), g_addr);
  assign g_wr_ok    = g_acc && g_wr && g_writable;

  assign fifo_level = level_q;
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  assign m0_push    = m0_write && (m0_address == WRITE_FIFO_ADDR);
  assign h_push     = g_wr_ok && (g_addr == WRITE_FIFO_ADDR);
  assign m0_pop_req = m0_read && (m0_address == READ_FIFO_ADDR);
  assign h_pop_req  = g_acc && g_rd && (g_addr == READ_FIFO_ADDR);
  assign pop        = (m0_pop_req || h_pop_req) && !fifo_empty;
  assign push       = (m0_push || h_push) && (!fifo_full || pop);
  assign ovf_evt    = (m0_push || h_push) && fifo_full && !pop;
  assign h_ovf      = h_push && fifo_full && !pop;
  assign unf_evt    = (m0_pop_req || h_pop_req) && fifo_empty;
  assign clear      = (m0_write && (m0_address == COMMAND_TRIGGER_ADDR) && (|m0_writedata[2:1])) ||
                      (g_wr_ok && (g_addr == COMMAND_TRIGGER_ADDR) && (|g_wdata[2:1]));
  assign push_data  = m0_push ? m0_writedata : g_wdata;

  assign head    = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
  assign m0_rval = ((m0_address == WRITE_FIFO_ADDR) || (m0_address == READ_FIFO_ADDR)) ?
                   head : mem_q[m0_address];
  assign h_rval  = ((g_addr == WRITE_FIFO_ADDR) || (g_addr == READ_FIFO_ADDR)) ?
                   head : mem_q[g_addr];

  assign h_waitrequest = h_req & ~(grant & {NUM_HOSTS{!stall}});
  assign h_invalid_cmd = grant & {NUM_HOSTS{(g_acc && g_wr && !g_writable) || h_ovf}};
  assign db_set        = grant & {NUM_HOSTS{g_wr_ok && (g_addr == COMMAND_TRIGGER_ADDR)}};

  always_comb begin
    level_d = level_q;
    if (clear)             level_d = '0;
    else if (push && !pop) level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // Storage is not reset; stall rules keep the two RAM writers off the same address.
  always_ff @(posedge clk) begin
    if (m0_write) mem_q[m0_address] <= m0_writedata;
    if (g_wr_ok)  mem_q[g_addr]     <= g_wdata;
    if (push)     fifo_mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      irq_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      h_rvalid_q  <= '0;
      h_rdata_q   <= '0;
    end else begin
      m0_rvalid_q <= m0_read;
      m0_rdata_q  <= m0_read ? m0_rval : 8'h00;
      h_rvalid_q  <= grant & {NUM_HOSTS{g_acc && g_rd}};
      h_rdata_q   <= (g_acc && g_rd) ? h_rval : 8'h00;
      irq_q       <= (irq_q & ~doorbell_ack) | db_set;
      level_q     <= level_d;
      if (clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        if (push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (ovf_evt) ovf_q    <= 1'b1;
        if (unf_evt) unf_q    <= 1'b1;
      end
    end
  end

  assign m0_readdata      = {24'h0, m0_rdata_q};
  assign m0_readdatavalid = m0_rvalid_q;
  assign h_readdatavalid  = h_rvalid_q;
  assign doorbell_irq     = irq_q;
  assign fifo_overflow    = ovf_q;
  assign fifo_underflow   = unf_q;

  always_comb begin
    h_readdata = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      h_readdata[i*32 +: 8] = h_rvalid_q[i] ? h_rdata_q : 8'h00;
    end
  end

endmodule

// File: tb/tb_smbus_mailbox_mp_reg_file.sv
// Directed bench for the multi-host mailbox: arbitration, protection, FIFO, doorbells, reset.
module tb_smbus_mailbox_mp_reg_file;
  import platform_defs_pkg::*;

  localparam int NH = 3;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_read, m0_write;
  logic [7:0]  m0_address, m0_writedata;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic [NH-1:0]    h_read, h_write;
  logic [8*NH-1:0]  h_address, h_writedata;
  logic [32*NH-1:0] h_readdata;
  logic [NH-1:0]    h_readdatavalid, h_waitrequest, h_invalid_cmd, doorbell_irq, doorbell_ack;
  logic [2:0]  fifo_level;
  logic        fifo_full, fifo_empty, fifo_overflow, fifo_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp3;

  smbus_mailbox_mp_reg_file #(.NUM_HOSTS(NH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .resetn(resetn),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .h_read(h_read), .h_write(h_write), .h_address(h_address),
    .h_writedata(h_writedata), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid), .h_waitrequest(h_waitrequest),
    .h_invalid_cmd(h_invalid_cmd), .doorbell_irq(doorbell_irq),
    .doorbell_ack(doorbell_ack), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
    h_read = '0; h_write = '0; h_address = '0; h_writedata = '0; doorbell_ack = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input int i, input logic rd, input logic wr,
                      input logic [7:0] addr, input logic [7:0] data);
    h_read[i]            = rd;
    h_write[i]           = wr;
    h_address[i*8 +: 8]  = addr;
    h_writedata[i*8 +: 8] = data;
  endtask

  task automatic m0(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetn = 0;
    repeat (3) step();
    resetn = 1;
    #1;
    chk("rst_m0_valid", m0_readdatavalid, 0);
    chk("rst_h_valid", h_readdatavalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_flags", {fifo_overflow, fifo_underflow}, 0);
    chk("rst_irq", doorbell_irq, 0);
    chk("rst_wait", h_waitrequest, 0);

    // preload a non-host-writable location
    m0(0, 1, 8'h10, 8'h77);
    step();
    idle();

    // round-robin: all three hosts read continuously
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NH; i++) host(i, 1, 0, 8'h10, 8'h00);
      #1;
      exp3 = 3'b111 & ~(3'b001 << (c % 3));
      chk("arb_wait", h_waitrequest, exp3);
      step();
      chk("arb_valid", h_readdatavalid, ~exp3 & 3'b111);
      chk("arb_data", h_readdata[(c % 3)*32 +: 32], 32'h77);
    end
    idle();
    step();
    chk("arb_valid_end", h_readdatavalid, 0);

    // write protection
    host(1, 0, 1, 8'h10, 8'h55);
    #1;
    chk("wp_invalid", h_invalid_cmd, 3'b010);
    chk("wp_wait", h_waitrequest, 0);
    step();
    idle();
    #1;
    chk("wp_invalid_end", h_invalid_cmd, 0);
    m0(1, 0, 8'h10, 8'h00);
    step();
    idle();
    chk("wp_m0_valid", m0_readdatavalid, 1);
    chk("wp_old_value", m0_readdata, 32'h77);
    step();
    chk("m0_valid_low", m0_readdatavalid, 0);
    chk("m0_data_zero", m0_readdata, 0);

    // fifo overflow
    for (int b = 0; b <= FD; b++) begin
      m0(0, 1, WRITE_FIFO_ADDR, 8'(b));
      step();
    end
    idle();
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", fifo_overflow, 1);
    chk("ovf_level", fifo_level, FD);
    host(0, 1, 0, READ_FIFO_ADDR, 8'h00);
    #1;
    chk("pop_wait", h_waitrequest, 0);
    step();
    idle();
    chk("pop_valid", h_readdatavalid, 3'b001);
    chk("pop_data", h_readdata[31:0], 32'h00);
    chk("pop_level", fifo_level, FD - 1);
    chk("pop_not_full", fifo_full, 0);
    m0(1, 0, WRITE_FIFO_ADDR, 8'h00);
    step();
    idle();
    chk("peek_data", m0_readdata, 32'h01);
    chk("peek_level", fifo_level, FD - 1);
    for (int b = 1; b < FD; b++) begin
      m0(1, 0, READ_FIFO_ADDR, 8'h00);
      step();
      chk("drain_data", m0_readdata, b);
    end
    idle();
    chk("drain_empty", fifo_empty, 1);
    chk("drain_level", fifo_level, 0);

    // underflow, clear via host trigger, doorbell set/ack
    m0(1, 0, READ_FIFO_ADDR, 8'h00);
    step();
    idle();
    chk("unf_valid", m0_readdatavalid, 1);
    chk("unf_data", m0_readdata, 0);
    chk("unf_flag", fifo_underflow, 1);
    chk("unf_level", fifo_level, 0);
    host(0, 0, 1, COMMAND_TRIGGER_ADDR, 8'h02);
    #1;
    chk("trig_wait", h_waitrequest, 0);
    chk("trig_invalid", h_invalid_cmd, 0);
    step();
    idle();
    chk("clr_flags", {fifo_overflow, fifo_underflow}, 0);
    chk("db_set", doorbell_irq, 3'b001);
    host(0, 0, 1, COMMAND_TRIGGER_ADDR, 8'h00);
    doorbell_ack = 3'b001;
    step();
    idle();
    chk("db_set_wins", doorbell_irq, 3'b001);
    doorbell_ack = 3'b001;
    step();
    idle();
    chk("db_ack", doorbell_irq, 0);

    // clear needs data[2:1] nonzero
    m0(0, 1, WRITE_FIFO_ADDR, 8'hAA);
    step();
    m0(0, 1, WRITE_FIFO_ADDR, 8'hBB);
    step();
    m0(0, 1, COMMAND_TRIGGER_ADDR, 8'h01);
    step();
    idle();
    chk("noclr_level", fifo_level, 2);
    m0(0, 1, COMMAND_TRIGGER_ADDR, 8'h04);
    step();
    idle();
    chk("clr_level", fifo_level, 0);
    chk("clr_empty", fifo_empty, 1);

    // same-address collision
    m0(0, 1, 8'h90, 8'hA5);
    host(1, 0, 1, 8'h90, 8'h3C);
    #1;
    chk("col_stall", h_waitrequest, 3'b010);
    step();
    m0(0, 0, 8'h00, 8'h00);
    #1;
    chk("col_go", h_waitrequest, 0);
    step();
    idle();
    m0(1, 0, 8'h90, 8'h00);
    step();
    idle();
    chk("col_final", m0_readdata, 32'h3C);

    // mid-operation reset
    host(1, 0, 1, COMMAND_TRIGGER_ADDR, 8'h00);
    step();
    idle();
    m0(0, 1, WRITE_FIFO_ADDR, 8'h5A);
    step();
    idle();
    host(0, 1, 0, 8'h10, 8'h00);
    step();
    idle();
    chk("pre_rst_irq", doorbell_irq, 3'b010);
    chk("pre_rst_level", fifo_level, 1);
    host(0, 1, 0, 8'h10, 8'h00);
    resetn = 0;
    #1;
    chk("rst_accept", h_waitrequest, 0);
    step();
    idle();
    chk("rst_squash", h_readdatavalid, 0);
    chk("rst_level2", fifo_level, 0);
    chk("rst_irq2", doorbell_irq, 0);
    resetn = 1;
    step();
    host(0, 1, 0, 8'h10, 8'h00);
    host(1, 1, 0, 8'h10, 8'h00);
    #1;
    chk("rst_ptr_wait", h_waitrequest, 3'b010);
    step();
    idle();
    chk("rst_ptr_valid", h_readdatavalid, 3'b001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
